// File: rtl/graphite_cmd_pkg.sv
// Shared constants and types for the graphite host command queue.
package graphite_cmd_pkg;

    localparam int unsigned CMD_DATA_WIDTH = 32;
    localparam int unsigned CMD_COUNT_W    = 32;

    typedef logic [CMD_DATA_WIDTH-1:0] cmd_word_t;

endpackage

// File: rtl/graphite_fifo_mem.sv
// Storage array for the command queue: one registered write port and one
// asynchronous read port.
module graphite_fifo_mem #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/graphite_cmd_fifo.sv
// Host command queue feeding the graphite AXI-stream command slave, with
// fill level, sticky overflow and a downstream handshake counter.
module graphite_cmd_fifo
    import graphite_cmd_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_WIDTH = CMD_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   wr_en_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH_LOG2:0]    level_o,
    output logic                   overflow_o,
    output logic [CMD_COUNT_W-1:0] cmd_count_o,
    output logic                   cmd_axis_tvalid_o,
    input  logic                   cmd_axis_tready_i,
    output logic [DATA_WIDTH-1:0]  cmd_axis_tdata_o
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;
    logic [CMD_COUNT_W-1:0] r_cmd_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Flags come from the registered level, so a same-cycle pop never frees
    // space for a push that arrives while full.
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = wr_en_i & ~w_full & ~flush_i;
    assign w_pop   = ~w_empty & cmd_axis_tready_i;

    graphite_fifo_mem #(
        .ADDR_W(DEPTH_LOG2),
        .DATA_W(DATA_WIDTH)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_push & ~reset_i),
        .i_waddr(r_wr_ptr),
        .i_wdata(wr_data_i),
        .i_raddr(r_rd_ptr),
        .o_rdata(cmd_axis_tdata_o)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_cmd_count <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + DEPTH_LOG2'(1);
                r_cmd_count <= r_cmd_count + CMD_COUNT_W'(1);
            end
            if (wr_en_i && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign full_o            = w_full;
    assign empty_o           = w_empty;
    assign level_o           = r_level;
    assign overflow_o        = r_overflow;
    assign cmd_count_o       = r_cmd_count;
    assign cmd_axis_tvalid_o = ~w_empty;

endmodule

// File: tb/tb_graphite_cmd_fifo.sv
// Self-checking bench for graphite_cmd_fifo against a queue-based model.
module tb_graphite_cmd_fifo;
    import graphite_cmd_pkg::*;

    localparam int unsigned DL2 = 4;
    localparam int unsigned DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic            wr_en_i = 1'b0;
    cmd_word_t       wr_data_i = '0;
    logic            flush_i = 1'b0;
    logic            full_o;
    logic            empty_o;
    logic [DL2:0]    level_o;
    logic            overflow_o;
    logic [31:0]     cmd_count_o;
    logic            cmd_axis_tvalid_o;
    logic            cmd_axis_tready_i = 1'b0;
    cmd_word_t       cmd_axis_tdata_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of words plus the sticky flag and counter.
    cmd_word_t   m_q[$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_count = '0;

    graphite_cmd_fifo #(
        .DEPTH_LOG2(DL2),
        .DATA_WIDTH(32)
    ) dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .wr_en_i          (wr_en_i),
        .wr_data_i        (wr_data_i),
        .flush_i          (flush_i),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .level_o          (level_o),
        .overflow_o       (overflow_o),
        .cmd_count_o      (cmd_count_o),
        .cmd_axis_tvalid_o(cmd_axis_tvalid_o),
        .cmd_axis_tready_i(cmd_axis_tready_i),
        .cmd_axis_tdata_o (cmd_axis_tdata_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model at the edge, return at the
    // following falling edge where outputs are stable.
    task automatic cycle(input bit rst, input bit wr, input cmd_word_t d,
                         input bit fl, input bit tr);
        bit was_full;
        bit do_pop;
        reset_i = rst; wr_en_i = wr; wr_data_i = d; flush_i = fl; cmd_axis_tready_i = tr;
        @(posedge clk);
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_q.size() != 0) && tr;
        if (rst) begin
            m_q.delete(); m_ovf = 1'b0; m_count = '0;
        end else if (fl) begin
            m_q.delete(); m_ovf = 1'b0;
        end else begin
            if (do_pop) begin
                void'(m_q.pop_front());
                m_count = m_count + 32'd1;
            end
            if (wr && !was_full) m_q.push_back(d);
            if (wr && was_full) m_ovf = 1'b1;
        end
        @(negedge clk);
        reset_i = 1'b0; wr_en_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, 0, 0);
        checks++;
        if ({level_o, empty_o, full_o, cmd_axis_tvalid_o, overflow_o} !== {5'd0, 4'b1000} ||
            cmd_count_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: level=%0d empty=%b full=%b tvalid=%b ovf=%b count=%0d, want 0/1/0/0/0/0",
                     level_o, empty_o, full_o, cmd_axis_tvalid_o, overflow_o, cmd_count_o);
        end
        cycle(0, 1, 32'hA000_0001, 0, 0);
        checks++;
        if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== 32'hA000_0001 ||
            level_o !== 5'd1 || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL first_push: tvalid=%b tdata=%h level=%0d empty=%b, want 1/a0000001/1/0",
                     cmd_axis_tvalid_o, cmd_axis_tdata_o, level_o, empty_o);
        end
    endtask

    task automatic test_overflow_drain();
        cycle(1, 0, '0, 0, 0);
        for (int i = 1; i <= 16; i++) cycle(0, 1, cmd_word_t'(i), 0, 0);
        cycle(0, 1, 32'hDEAD, 0, 0);
        checks++;
        if (full_o !== 1'b1 || level_o !== 5'd16 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: full=%b level=%0d ovf=%b, want 1/16/1",
                     full_o, level_o, overflow_o);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== cmd_word_t'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: tvalid=%b tdata=%h, want 1/%h",
                         i, cmd_axis_tvalid_o, cmd_axis_tdata_o, i);
            end
            cycle(0, 0, '0, 0, 1);
        end
        checks++;
        if (cmd_count_o !== 32'd16 || empty_o !== 1'b1 || cmd_axis_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: count=%0d empty=%b tvalid=%b, want 16/1/0",
                     cmd_count_o, empty_o, cmd_axis_tvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        cmd_word_t base;
        base = $urandom;
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cycle(0, 1, base + cmd_word_t'(i), 0, 1);
            checks++;
            if (level_o !== 5'd1 || cmd_axis_tdata_o !== base + cmd_word_t'(i) ||
                cmd_count_o !== m_count) begin
                errors++;
                $display("FAIL b2b[%0d]: level=%0d tdata=%h count=%0d, want 1/%h/%0d",
                         i, level_o, cmd_axis_tdata_o, cmd_count_o, base + cmd_word_t'(i), m_count);
            end
        end
        checks++;
        if (cmd_count_o !== 32'd99) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, want 99", cmd_count_o);
        end
    endtask

    task automatic test_full_pop();
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, cmd_word_t'($urandom), 0, 0);
        cycle(0, 1, 32'hBAD0_0BAD, 0, 1);
        checks++;
        if (level_o !== 5'd15 || overflow_o !== 1'b1 || full_o !== 1'b0 ||
            cmd_axis_tdata_o !== m_q[0]) begin
            errors++;
            $display("FAIL full_pop: level=%0d ovf=%b full=%b tdata=%h, want 15/1/0/%h",
                     level_o, overflow_o, full_o, cmd_axis_tdata_o, m_q[0]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, cmd_word_t'(i + 100), 0, 0);
        cycle(0, 1, 32'h1234, 0, 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, '0, 0, 1);
        checks++;
        if (level_o !== 5'd5 || overflow_o !== 1'b1 || cmd_count_o !== 32'd11) begin
            errors++;
            $display("FAIL flush_setup: level=%0d ovf=%b count=%0d, want 5/1/11",
                     level_o, overflow_o, cmd_count_o);
        end
        cnt_before = cmd_count_o;
        cycle(0, 1, 32'h7777, 1, 1);
        checks++;
        if (level_o !== 5'd0 || cmd_axis_tvalid_o !== 1'b0 || overflow_o !== 1'b0 ||
            cmd_count_o !== 32'd11) begin
            errors++;
            $display("FAIL flush: level=%0d tvalid=%b ovf=%b count=%0d, want 0/0/0/%0d",
                     level_o, cmd_axis_tvalid_o, overflow_o, cmd_count_o, cnt_before);
        end
        cycle(0, 1, 32'h0F0F_0F0F, 0, 0);
        checks++;
        if (cmd_axis_tdata_o !== 32'h0F0F_0F0F || level_o !== 5'd1) begin
            errors++;
            $display("FAIL post_flush_push: tdata=%h level=%0d, want 0f0f0f0f/1",
                     cmd_axis_tdata_o, level_o);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, cmd_word_t'($urandom), 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, '0, 0, bit'($urandom_range(0, 1)));
        cycle(1, 1, 32'h9999, 0, bit'($urandom_range(0, 1)));
        checks++;
        if ({level_o, empty_o, full_o, cmd_axis_tvalid_o, overflow_o} !== {5'd0, 4'b1000} ||
            cmd_count_o !== 32'd0) begin
            errors++;
            $display("FAIL midstream_reset: level=%0d empty=%b full=%b tvalid=%b ovf=%b count=%0d",
                     level_o, empty_o, full_o, cmd_axis_tvalid_o, overflow_o, cmd_count_o);
        end
        cycle(0, 1, 32'h55, 0, 0);
        checks++;
        if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== 32'h55) begin
            errors++;
            $display("FAIL midstream_first: tvalid=%b tdata=%h, want 1/00000055",
                     cmd_axis_tvalid_o, cmd_axis_tdata_o);
        end
    endtask

    task automatic test_random();
        int unsigned lvl;
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cycle(0, bit'($urandom_range(0, 99) < 60), cmd_word_t'($urandom),
                  bit'($urandom_range(0, 99) < 2), bit'($urandom_range(0, 99) < 45));
            lvl = m_q.size();
            checks++;
            if (level_o !== 5'(lvl) || empty_o !== (lvl == 0) || full_o !== (lvl == DEPTH) ||
                cmd_axis_tvalid_o !== (lvl != 0) || overflow_o !== m_ovf ||
                cmd_count_o !== m_count || (lvl != 0 && cmd_axis_tdata_o !== m_q[0])) begin
                errors++;
                $display("FAIL random[%0d]: level=%0d ovf=%b count=%0d tdata=%h, want %0d/%b/%0d/%h",
                         i, level_o, overflow_o, cmd_count_o, cmd_axis_tdata_o,
                         lvl, m_ovf, m_count, (lvl != 0) ? m_q[0] : '0);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_overflow_drain();
        test_back_to_back();
        test_full_pop();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
